led_view_selector: RTL
======================

// Module: led_view_selector
// PURPOSE
//  Drives the 5-bit view select of the Simple Computer's 20-way 8-bit LED display mux.
//  Debounces NEXT/PREV pushbuttons to step through views, with wrap-around.
//  Accepts a direct view number from the board switches.
//  Has an auto-scan mode that advances the view after a fixed dwell time.
// PARAMETERS
//  NUM_VIEWS        20     number of valid views; select range 0..NUM_VIEWS-1 (max 32)
//  DEBOUNCE_CYCLES  1000   consecutive stable cycles needed to accept a button level (>=1)
//  SCAN_DWELL       100000 cycles each view is held in auto-scan (>=1)
// PORTS
//  clock        in   1  system clock; all state changes on its rising edge
//  reset        in   1  synchronous, active-high reset
//  btn_next     in   1  raw (asynchronous, bouncy) pushbutton: step to next view
//  btn_prev     in   1  raw (asynchronous, bouncy) pushbutton: step to previous view
//  scan_en      in   1  level; 1 = auto-scan mode, 0 = manual mode
//  direct_load  in   1  synchronous one-cycle strobe: load direct_sel
//  direct_sel   in   5  view number to load on direct_load
//  select       out  5  registered view select to the LED mux
//  view_changed out  1  high for exactly one cycle after each edge on which select changes
//  scan_active  out  1  registered; 1 while FSM is in SCAN
// BEHAVIOUR
//  Reset (clock edge with reset=1):
//   - select=0, view_changed=0, scan_active=0, FSM=MANUAL.
//   - All sync flops, debounced levels and counters cleared to 0.
//   - Reset overrides every other input on that edge.
//  Button path, applied to each button independently:
//   - 2-flop synchroniser sync1->sync2, then debounce counter cnt.
//   - If sync2==deb: cnt<=0.
//   - Else if cnt==DEBOUNCE_CYCLES-1: deb<=sync2, cnt<=0.
//   - Else: cnt<=cnt+1.
//   - Press event = registered one-cycle pulse on a deb 0->1 transition. Release events are ignored.
//   - Latency: raw high first sampled at edge k gives select update at edge k+DEBOUNCE_CYCLES+2.
//   - A raw pulse shorter than DEBOUNCE_CYCLES cycles (after sync) produces no event.
//   - A held button produces exactly one event; there is no auto-repeat.
//  Select update, one action per edge, in priority order:
//   1 direct_load=1:
//     - If direct_sel<NUM_VIEWS: select<=direct_sel.
//     - Else: ignore (no change, no pulse); lower-priority events on that edge are dropped.
//   2 next and prev events both present: no change; both events are consumed.
//   3 next event: select<=(select==NUM_VIEWS-1) ? 0 : select+1.
//   4 prev event: select<=(select==0) ? NUM_VIEWS-1 : select-1.
//   5 FSM=SCAN and dwell==SCAN_DWELL-1: advance as in 3.
//   - view_changed<=1 only if the new select differs from the old value.
//   - direct_load to the current value gives no pulse.
//  FSM:
//   - MANUAL -> SCAN when scan_en=1; dwell<=0.
//   - SCAN -> MANUAL when scan_en=0; dwell<=0.
//   - In SCAN: dwell increments each cycle and wraps to 0 on the advance.
//   - Any applied priority-1..4 action in SCAN also resets dwell to 0 (restarts the dwell).
//   - scan_active reflects the state after the edge.
//   - Entering SCAN at edge m gives the first advance at edge m+SCAN_DWELL.
//  Counter widths: $clog2 of the maximum count. No counter saturates; every counter is explicitly cleared as above.
//  select never holds a value >= NUM_VIEWS.
// TESTING (bench uses DEBOUNCE_CYCLES=4, SCAN_DWELL=8)
//  T1 reset held 3 cycles, all inputs 0 -> select=0, view_changed=0, scan_active=0; stable for 20 cycles after release.
//  T2 btn_next high from edge k for 12 cycles -> select 0->1 at edge k+6; one view_changed pulse.
//     Then a 3-cycle btn_next glitch -> no change.
//  T3 btn_prev press at select=0 -> 19; btn_next press at select=19 -> 0.
//     Both buttons pressed on the same cycle -> select unchanged, no pulse.
//  T4 direct_load with sel=7 -> select=7 next edge, with pulse.
//     direct_load with sel=25 -> select stays 7, no pulse.
//     direct_load with sel=7 while a next event is present -> 7, no pulse.
//  T5 select=18, scan_en rises at edge m -> 19 at m+8, 0 at m+16.
//     btn_next event at m+20 -> 1 and dwell restarts, so next advance at edge+8.
//     scan_en=0 -> scan_active=0 and no further advances.
//  T6 reset asserted mid-debounce and mid-scan -> all outputs 0 the next edge.
//     A btn_next still held after reset must re-debounce fully: select=1 at reset release+DEBOUNCE_CYCLES+2.

Source files
------------

// File: rtl/led_view_selector.sv
// led_view_selector
//   Generates the 5-bit view select for the 20-way LED display mux.
//   NEXT/PREV pushbuttons are synchronised and debounced, and each press
//   steps the view with wrap-around. A direct view number can be loaded
//   from the switches. In auto-scan mode the view advances after a fixed
//   dwell time.
//
// Ports
//   clock        in   system clock, rising-edge active
//   reset        in   synchronous, active-high reset
//   btn_next     in   raw pushbutton, step to next view
//   btn_prev     in   raw pushbutton, step to previous view
//   scan_en      in   1 = auto-scan mode, 0 = manual mode
//   direct_load  in   one-cycle strobe, load direct_sel
//   direct_sel   in   [4:0] view number to load
//   select       out  [4:0] registered view select
//   view_changed out  one-cycle pulse after each edge that changes select
//   scan_active  out  registered, 1 while in auto-scan
module led_view_selector #(
  parameter int NUM_VIEWS       = 20,
  parameter int DEBOUNCE_CYCLES = 1000,
  parameter int SCAN_DWELL      = 100000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       btn_next,
  input  logic       btn_prev,
  input  logic       scan_en,
  input  logic       direct_load,
  input  logic [4:0] direct_sel,
  output logic [4:0] select,
  output logic       view_changed,
  output logic       scan_active
);

  localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int DW_W = (SCAN_DWELL > 1) ? $clog2(SCAN_DWELL) : 1;

  localparam logic [DB_W-1:0] DB_LAST    = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [DW_W-1:0] DW_LAST    = DW_W'(SCAN_DWELL - 1);
  localparam logic [4:0]      LAST_VIEW  = 5'(NUM_VIEWS - 1);
  localparam logic [5:0]      VIEW_COUNT = 6'(NUM_VIEWS);

  localparam logic [0:0] ST_MANUAL = 1'b0;
  localparam logic [0:0] ST_SCAN   = 1'b1;

  // Button index 0 = next, 1 = prev.
  logic [1:0]            sync1;
  logic [1:0]            sync2;
  logic [1:0]            deb;
  logic [1:0]            press;
  logic [1:0][DB_W-1:0]  cnt;

  logic [0:0]            state;
  logic [0:0]            state_nxt;
  logic [DW_W-1:0]       dwell;

  logic [4:0]            sel_inc;
  logic [4:0]            sel_dec;
  logic [4:0]            sel_nxt;
  logic                  action;

  // Synchroniser and debouncer. The press pulse is raised on the same edge
  // that deb rises, so it is registered yet costs no extra cycle of latency.
  always_ff @(posedge clock) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
      deb   <= '0;
      press <= '0;
      cnt   <= '0;
    end else begin
      sync1 <= {btn_prev, btn_next};
      sync2 <= sync1;
      for (int unsigned i = 0; i < 2; i++) begin
        press[i] <= 1'b0;
        if (sync2[i] == deb[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == DB_LAST) begin
          deb[i]   <= sync2[i];
          cnt[i]   <= '0;
          press[i] <= sync2[i];
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  // Next select value, one action per edge in priority order. An invalid
  // direct_load still claims the edge, blocking every lower-priority event.
  always_comb begin
    sel_inc   = (select == LAST_VIEW) ? '0 : select + 5'd1;
    sel_dec   = (select == '0) ? LAST_VIEW : select - 5'd1;
    sel_nxt   = select;
    action    = 1'b0;
    state_nxt = scan_en ? ST_SCAN : ST_MANUAL;
    if (direct_load) begin
      if ({1'b0, direct_sel} < VIEW_COUNT) begin
        sel_nxt = direct_sel;
        action  = 1'b1;
      end
    end else if (press[0] && press[1]) begin
      action = 1'b1;
    end else if (press[0]) begin
      sel_nxt = sel_inc;
      action  = 1'b1;
    end else if (press[1]) begin
      sel_nxt = sel_dec;
      action  = 1'b1;
    end else if (state == ST_SCAN && dwell == DW_LAST) begin
      sel_nxt = sel_inc;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      select       <= '0;
      view_changed <= 1'b0;
      scan_active  <= 1'b0;
      state        <= ST_MANUAL;
      dwell        <= '0;
    end else begin
      select       <= sel_nxt;
      view_changed <= (sel_nxt != select);
      scan_active  <= (state_nxt == ST_SCAN);
      state        <= state_nxt;
      // Dwell restarts on mode change, on any manual action and on advance.
      if (state != ST_SCAN || state_nxt != ST_SCAN || action || dwell == DW_LAST) begin
        dwell <= '0;
      end else begin
        dwell <= dwell + 1'b1;
      end
    end
  end

endmodule
